// File: rtl/mopshub_bus_init_sequencer.sv
// MOPSHUB CAN bus power-up and oscillator trim sequencer.
// Walks buses 0..n_buses-1: power pulse, settle, optional supervised trim.
module mopshub_bus_init_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int TRIM_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  n_buses,
  input  logic        trim_en,
  input  logic        trim_done,
  output logic        power_bus_en,
  output logic [4:0]  power_bus_cnt,
  output logic        start_trim,
  output logic        end_power_init,
  output logic        busy,
  output logic [31:0] trim_fail
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TRIM_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    POWER,
    SETTLE,
    TRIM_REQ,
    TRIM_WAIT,
    NEXT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [4:0]  n_lat;
  logic        te_lat;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic        settle_end;
  logic        tout;
  logic        last;

  assign settle_end = (scnt == SW'(SETTLE_CYCLES - 1));
  assign tout       = (tcnt == TW'(TRIM_TIMEOUT - 1));
  assign last       = (power_bus_cnt == n_lat - 5'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = (n_buses == 5'd0) ? DONE : POWER;
      end
      POWER:    state_n = SETTLE;
      SETTLE: begin
        if (settle_end) state_n = te_lat ? TRIM_REQ : NEXT;
      end
      TRIM_REQ: state_n = TRIM_WAIT;
      TRIM_WAIT: begin
        if (trim_done || tout) state_n = NEXT;
      end
      NEXT:     state_n = last ? DONE : POWER;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Latched config, bus index, counters and trim failure flags
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat         <= '0;
      te_lat        <= 1'b0;
      power_bus_cnt <= '0;
      trim_fail     <= '0;
      scnt          <= '0;
      tcnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            n_lat         <= n_buses;
            te_lat        <= trim_en;
            trim_fail     <= '0;
            power_bus_cnt <= '0;
          end
        end
        POWER:    scnt <= '0;
        SETTLE:   scnt <= scnt + SW'(1);
        TRIM_REQ: tcnt <= '0;
        TRIM_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (!trim_done && tout) trim_fail[power_bus_cnt] <= 1'b1;
        end
        NEXT: begin
          if (!last) power_bus_cnt <= power_bus_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state
  always_comb begin
    power_bus_en   = (state == POWER);
    start_trim     = (state == TRIM_REQ);
    end_power_init = (state == DONE);
    busy           = (state != IDLE);
  end

endmodule

// File: tb/tb_mopshub_bus_init_sequencer.sv
// Scoreboard bench for mopshub_bus_init_sequencer.
// A timeline model predicts every output pulse; a monitor pops and checks.
module tb_mopshub_bus_init_sequencer;

  localparam int S = 16;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  n_buses = '0;
  logic        trim_en = 1'b0;
  logic        trim_done = 1'b0;
  logic        power_bus_en;
  logic [4:0]  power_bus_cnt;
  logic        start_trim;
  logic        end_power_init;
  logic        busy;
  logic [31:0] trim_fail;

  mopshub_bus_init_sequencer #(
    .SETTLE_CYCLES(S),
    .TRIM_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .n_buses(n_buses),
    .trim_en(trim_en),
    .trim_done(trim_done),
    .power_bus_en(power_bus_en),
    .power_bus_cnt(power_bus_cnt),
    .start_trim(start_trim),
    .end_power_init(end_power_init),
    .busy(busy),
    .trim_fail(trim_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          cyc;
    logic [4:0]  cnt;
    logic [31:0] fail;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  ec = 0;
  int  win_d = 0;
  int  win_end = 0;
  int  dly[32];
  bit  done_at[int];

  always @(posedge clk) ec <= ec + 1;

  // Monitor: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    ev_t e;
    int  k;
    int  rel;
    bit  eb;
    if (power_bus_en || start_trim || end_power_init) begin
      k = end_power_init ? 2 : (start_trim ? 1 : 0);
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse kind=%0d ec=%0d cnt=%0d",
                 k, ec, power_bus_cnt);
      end else begin
        e = q.pop_front();
        if (k != e.kind || ec != e.cyc || power_bus_cnt !== e.cnt ||
            (k == 2 && trim_fail !== e.fail) ||
            (power_bus_en + start_trim + end_power_init) != 1) begin
          n_fail++;
          $display("FAIL pulse got kind=%0d ec=%0d cnt=%0d fail=%h exp kind=%0d ec=%0d cnt=%0d fail=%h",
                   k, ec, power_bus_cnt, trim_fail,
                   e.kind, e.cyc, e.cnt, e.fail);
        end
      end
    end
    rel = ec - win_d;
    eb = (rel >= 1) && (rel <= win_end);
    n_chk++;
    if (busy !== eb) begin
      n_fail++;
      $display("FAIL busy ec=%0d got=%0b exp=%0b", ec, busy, eb);
    end
  end

  // Build the expected timeline for one sequence and drive it
  task automatic run_seq(input int n, input bit te, input bit spur,
                         input int extra, input int abort);
    int t;
    int p;
    int d0;
    int last;
    logic [31:0] f;
    ev_t e;
    d0 = ec + 1;
    t = 0;
    f = '0;
    done_at.delete();
    for (int b = 0; b < n; b++) begin
      t++;
      p = t;
      e = '{0, d0 + t, 5'(b), 32'h0};
      if (abort < 0 || t <= abort) q.push_back(e);
      if (spur) done_at[p + 1] = 1'b1;
      t += S;
      if (te) begin
        t++;
        e = '{1, d0 + t, 5'(b), 32'h0};
        if (abort < 0 || t <= abort) q.push_back(e);
        if (dly[b] >= 1 && dly[b] <= T) begin
          done_at[t + dly[b]] = 1'b1;
          t += dly[b];
        end else begin
          t += T;
          f[b] = 1'b1;
        end
      end
      t++;
    end
    t++;
    e = '{2, d0 + t, (n == 0) ? 5'd0 : 5'(n - 1), f};
    if (abort < 0 || t <= abort) q.push_back(e);
    win_d = d0;
    win_end = (abort >= 0 && abort < t) ? abort : t;
    last = (abort >= 0 && abort < t) ? abort + 1 : t;
    for (int r = 0; r <= last; r++) begin
      @(negedge clk);
      start     = (r == 0) || (r == extra);
      n_buses   = 5'(n);
      trim_en   = te;
      trim_done = done_at.exists(r);
      rst       = (r == abort);
      if (abort >= 0 && r == abort + 1) begin
        n_chk++;
        if ({power_bus_en, start_trim, end_power_init, busy} !== 4'b0 ||
            power_bus_cnt !== 5'd0 || trim_fail !== 32'h0) begin
          n_fail++;
          $display("FAIL abort_reset en=%0b st=%0b end=%0b busy=%0b cnt=%0d fail=%h exp all 0",
                   power_bus_en, start_trim, end_power_init,
                   busy, power_bus_cnt, trim_fail);
        end
      end
    end
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic gap(input int g);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      start = 1'b0;
      trim_done = 1'b0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dly[i] = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({power_bus_en, start_trim, end_power_init, busy} !== 4'b0 ||
        power_bus_cnt !== 5'd0 || trim_fail !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state cnt=%0d fail=%h busy=%0b exp 0",
               power_bus_cnt, trim_fail, busy);
    end
    rst = 1'b0;
    #1;
    dly[0] = 5;
    run_seq(1, 1'b1, 1'b0, -1, -1);
    gap(2);
    run_seq(3, 1'b0, 1'b0, -1, -1);
    dly[0] = 3;
    dly[1] = 0;
    run_seq(2, 1'b1, 1'b0, -1, -1);
    dly[0] = T;
    dly[1] = T;
    run_seq(2, 1'b1, 1'b1, -1, -1);
    run_seq(0, 1'b1, 1'b0, -1, -1);
    gap(1);
    run_seq(3, 1'b0, 1'b0, -1, 22);
    gap(2);
    dly[0] = 2;
    dly[1] = 0;
    run_seq(2, 1'b1, 1'b0, 7, -1);
    run_seq(31, 1'b0, 1'b0, 40, -1);
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 32; i++) dly[i] = $urandom_range(0, T);
      run_seq($urandom_range(0, 5), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : -1,
              -1);
      gap($urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mopshub_bus_init_sequencer.md
# mopshub_bus_init_sequencer

Sequences the power-up and oscillator trimming of the MOPSHUB CAN buses after reset. On a start pulse it walks bus indices 0 to n_buses-1. For each bus it pulses the bus power enable, waits a settle time, then optionally requests and supervises the oscillator trim with a timeout. It sits between the MOPSHUB top-level init logic and the per-bus power/trim engines, and replaces ad-hoc counting of power_bus_cnt.

## Interface
Parameters:
- SETTLE_CYCLES, 16: cycles spent in SETTLE after each bus power pulse (≥1).
- TRIM_TIMEOUT, 4096: maximum cycles spent in TRIM_WAIT per bus (≥1).

Ports:
- clk  in  1  system clock (40 MHz domain); single clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin the init sequence; sampled only in IDLE.
- n_buses  in  5  number of buses to initialise; latched at start; 0 = none.
- trim_en  in  1  osc_auto_trim enable; latched at start; 0 skips trimming.
- trim_done  in  1  end-of-trim pulse from the trim engine; honoured only in TRIM_WAIT.
- power_bus_en  out  1  one-cycle pulse; enables power of bus power_bus_cnt.
- power_bus_cnt  out  5  current bus index.
- start_trim  out  1  one-cycle trim request for bus power_bus_cnt.
- end_power_init  out  1  one-cycle pulse when the sequence completes.
- busy  out  1  high in every state except IDLE.
- trim_fail  out  32  bit i set when bus i timed out during trim; cleared on accepted start.

## Operation
- States: IDLE, POWER, SETTLE, TRIM_REQ, TRIM_WAIT, NEXT, DONE. All outputs are Moore, decoded from the state register or held in registers.
- IDLE, start=1:
  - latch n_buses and trim_en; clear trim_fail; power_bus_cnt←0.
  - go to DONE if the latched n_buses = 0, else go to POWER.
- IDLE, start=0: stay. start in any other state is ignored.
- POWER: power_bus_en=1 for one cycle; reset the settle counter; → SETTLE.
- SETTLE: stays exactly SETTLE_CYCLES cycles; then → TRIM_REQ if latched trim_en=1, else → NEXT.
- TRIM_REQ: start_trim=1 for one cycle; reset the timeout counter; → TRIM_WAIT.
- TRIM_WAIT:
  - trim_done=1 → NEXT.
  - Otherwise, after TRIM_TIMEOUT cycles in this state: set trim_fail[power_bus_cnt], → NEXT.
  - If trim_done and the timeout expire in the same cycle, done wins and no fail bit is set.
- NEXT:
  - if power_bus_cnt = n_buses-1 → DONE.
  - else power_bus_cnt+1, → POWER.
  - Compare at 5-bit width; no wrap, since the maximum index is 30.
- DONE: end_power_init=1 for one cycle; → IDLE. power_bus_cnt holds its last value.
- trim_done outside TRIM_WAIT has no effect.
- Counters are sized ceil(log2(parameter))+1 bits and saturate-free. They are reset on state entry only.

## Timing
- Reset values: state IDLE, power_bus_cnt=0, trim_fail=0, and power_bus_en, start_trim, end_power_init, busy all 0.
- rst=1 at any time returns the block to IDLE on the next edge. All outputs take their reset values and no completion pulse is issued. A mid-sequence reset abandons the sequence.
- Cycle numbering: cycle 0 is the edge sampling start in IDLE; cycle k is k edges later.
- Per bus, trim disabled: POWER 1 cycle, SETTLE SETTLE_CYCLES cycles, NEXT 1 cycle.
- Per bus, trim enabled, done in cycle d of TRIM_WAIT (d counted from 1): POWER 1 + SETTLE SETTLE_CYCLES + TRIM_REQ 1 + TRIM_WAIT d + NEXT 1.
- Per bus, trim timed out: TRIM_WAIT lasts TRIM_TIMEOUT cycles.
- DONE is 1 cycle after the final NEXT; busy drops in the following cycle.
- Back-to-back: start in the first IDLE cycle after DONE is accepted.

## Test plan
- n_buses=1, trim_en=1, SETTLE_CYCLES=16, trim_done pulsed 5 cycles after start_trim -> power_bus_en at cycle 1, start_trim at cycle 18, end_power_init at cycle 25, busy=0 at cycle 26, trim_fail=0.
- n_buses=3, trim_en=0 -> power_bus_en at cycles 1/19/37 with power_bus_cnt 0/1/2, no start_trim, end_power_init at cycle 55.
- n_buses=2, trim_en=1, TRIM_TIMEOUT=8, trim_done never for bus 1 -> trim_fail=32'h2 at completion; bus 1 TRIM_WAIT lasts exactly 8 cycles.
- trim_done asserted in the same cycle the timeout expires -> no fail bit. trim_done pulsed during SETTLE -> ignored; the state still waits in TRIM_WAIT.
- n_buses=0 with start -> no power_bus_en; end_power_init at cycle 1.
- rst=1 during bus 1 SETTLE -> next cycle all outputs 0, IDLE. Second start while busy -> ignored, sequence timing unchanged.
